// File: rtl/usb_pkg.sv
// Shared constants for the USB packet encoder: PID nibbles, FSM encoding
// and CRC16 parameters.
package usb_pkg;

   localparam logic [3:0] PID_ACK   = 4'b0010;
   localparam logic [3:0] PID_NAK   = 4'b1010;
   localparam logic [3:0] PID_STALL = 4'b1110;
   localparam logic [3:0] PID_NYET  = 4'b0110;
   localparam logic [3:0] PID_OUT   = 4'b0001;
   localparam logic [3:0] PID_IN    = 4'b1001;
   localparam logic [3:0] PID_SOF   = 4'b0101;
   localparam logic [3:0] PID_SETUP = 4'b1101;
   localparam logic [3:0] PID_DATA0 = 4'b0011;
   localparam logic [3:0] PID_DATA1 = 4'b1011;
   localparam logic [3:0] PID_DATA2 = 4'b0111;
   localparam logic [3:0] PID_MDATA = 4'b1111;

   // Low two PID bits select the packet class; the caller supplies the upper two.
   localparam logic [1:0] PID_SUF_HSK  = 2'b10;
   localparam logic [1:0] PID_SUF_TOK  = 2'b01;
   localparam logic [1:0] PID_SUF_DATA = 2'b11;

   localparam logic [15:0] CRC16_INIT      = 16'hFFFF;
   localparam logic [15:0] CRC16_POLY_REFL = 16'hA001;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_PID,
      ST_TOK1,
      ST_TOK2,
      ST_PAYLOAD,
      ST_CRC_LO,
      ST_CRC_HI,
      ST_DONE
   } enc_state_t;

   typedef enum logic [1:0] {
      KIND_HSK,
      KIND_TOK,
      KIND_DATA
   } pkt_kind_t;

   function automatic logic [7:0] pid_byte(input logic [3:0] pid);
      return {~pid, pid};
   endfunction

endpackage

// File: rtl/usb_crc16_byte.sv
// Combinational one-byte update of the USB data CRC16 (reflected 0x8005),
// bits consumed LSB first.
module usb_crc16_byte
   import usb_pkg::*;
(
   input  logic [15:0] crc_i,
   input  logic [7:0]  data_i,
   output logic [15:0] crc_o
);

   logic [15:0] crc_work;

   always_comb begin
      crc_work = crc_i;
      for (int i = 0; i < 8; i++) begin
         if (crc_work[0] ^ data_i[i]) begin
            crc_work = (crc_work >> 1) ^ CRC16_POLY_REFL;
         end else begin
            crc_work = crc_work >> 1;
         end
      end
      crc_o = crc_work;
   end

endmodule

// File: rtl/usb_packet_encoder.sv
// Byte-wide USB 2.0 TX packet encoder (handshake / token / data + CRC16).
// Optional USB_ENC_TVALID_END_EN: a payload gap (trn_tvalid_i low) ends the payload.
module usb_packet_encoder
   import usb_pkg::*;
(
   input  logic        clock,
   input  logic        reset,
   output logic        tx_tvalid_o,
   input  logic        tx_tready_i,
   output logic        tx_tlast_o,
   output logic [7:0]  tx_tdata_o,
   input  logic        hsk_send_i,
   output logic        hsk_done_o,
   input  logic [1:0]  hsk_type_i,
   input  logic        tok_send_i,
   output logic        tok_done_o,
   input  logic [1:0]  tok_type_i,
   input  logic [15:0] tok_data_i,
   input  logic        trn_start_i,
   input  logic [1:0]  trn_type_i,
   input  logic        trn_tvalid_i,
   output logic        trn_tready_o,
   input  logic        trn_tlast_i,
   input  logic [7:0]  trn_tdata_i
);

   enc_state_t  state_reg, state_next;
   pkt_kind_t   kind_reg, kind_next;
   logic [15:0] tok_reg, tok_next;
   logic [15:0] crc_reg, crc_next;
   logic        trn_pend_reg, trn_pend_next;
   logic        zlp_reg, zlp_next;
   logic [1:0]  trn_type_reg, trn_type_next;
   logic        tx_tvalid_reg, tx_tvalid_next;
   logic        tx_tlast_reg, tx_tlast_next;
   logic [7:0]  tx_tdata_reg, tx_tdata_next;

   logic [15:0] crc_upd;
   logic        out_free;
   logic        out_accept;
   logic        pay_ready;
   logic [1:0]  data_type_sel;

   usb_crc16_byte u_crc (
      .crc_i  (crc_reg),
      .data_i (trn_tdata_i),
      .crc_o  (crc_upd)
   );

   // The output register can take a new byte when empty or being drained this cycle.
   assign out_free      = !tx_tvalid_reg || tx_tready_i;
   assign out_accept    = tx_tvalid_reg && tx_tready_i;
   assign pay_ready     = (state_reg == ST_PAYLOAD) && out_free;
   assign data_type_sel = trn_start_i ? trn_type_i : trn_type_reg;

   always_comb begin
      state_next     = state_reg;
      kind_next      = kind_reg;
      tok_next       = tok_reg;
      crc_next       = crc_reg;
      trn_pend_next  = trn_pend_reg | trn_start_i;
      zlp_next       = trn_start_i ? !trn_tvalid_i : zlp_reg;
      trn_type_next  = data_type_sel;
      tx_tvalid_next = tx_tvalid_reg;
      tx_tlast_next  = tx_tlast_reg;
      tx_tdata_next  = tx_tdata_reg;

      case (state_reg)
         ST_IDLE: begin
            if (hsk_send_i) begin
               kind_next      = KIND_HSK;
               tx_tvalid_next = 1'b1;
               tx_tlast_next  = 1'b1;
               tx_tdata_next  = pid_byte({hsk_type_i, PID_SUF_HSK});
               state_next     = ST_PID;
            end else if (tok_send_i) begin
               kind_next      = KIND_TOK;
               tok_next       = tok_data_i;
               tx_tvalid_next = 1'b1;
               tx_tlast_next  = 1'b0;
               tx_tdata_next  = pid_byte({tok_type_i, PID_SUF_TOK});
               state_next     = ST_PID;
            end else if (trn_start_i || trn_pend_reg) begin
               kind_next      = KIND_DATA;
               crc_next       = CRC16_INIT;
               trn_pend_next  = 1'b0;
               tx_tvalid_next = 1'b1;
               tx_tlast_next  = 1'b0;
               tx_tdata_next  = pid_byte({data_type_sel, PID_SUF_DATA});
               state_next     = ST_PID;
            end
         end
         ST_PID: begin
            if (out_accept) begin
               case (kind_reg)
                  KIND_HSK: begin
                     tx_tvalid_next = 1'b0;
                     state_next     = ST_DONE;
                  end
                  KIND_TOK: begin
                     tx_tdata_next = tok_reg[7:0];
                     tx_tlast_next = 1'b0;
                     state_next    = ST_TOK1;
                  end
                  default: begin
                     tx_tvalid_next = 1'b0;
                     state_next     = zlp_reg ? ST_CRC_LO : ST_PAYLOAD;
                  end
               endcase
            end
         end
         ST_TOK1: begin
            if (out_accept) begin
               tx_tdata_next = tok_reg[15:8];
               tx_tlast_next = 1'b1;
               state_next    = ST_TOK2;
            end
         end
         ST_TOK2: begin
            if (out_accept) begin
               tx_tvalid_next = 1'b0;
               state_next     = ST_DONE;
            end
         end
         ST_PAYLOAD: begin
            if (out_free) begin
               if (trn_tvalid_i) begin
                  tx_tvalid_next = 1'b1;
                  tx_tlast_next  = 1'b0;
                  tx_tdata_next  = trn_tdata_i;
                  crc_next       = crc_upd;
                  if (trn_tlast_i) begin
                     state_next = ST_CRC_LO;
                  end
               end else begin
                  tx_tvalid_next = 1'b0;
`ifdef USB_ENC_TVALID_END_EN
                  state_next     = ST_CRC_LO;
`endif
               end
            end
         end
         ST_CRC_LO: begin
            if (out_free) begin
               tx_tvalid_next = 1'b1;
               tx_tlast_next  = 1'b0;
               tx_tdata_next  = ~crc_reg[7:0];
               state_next     = ST_CRC_HI;
            end
         end
         ST_CRC_HI: begin
            // Output holds the low CRC byte first, then the high byte flagged tlast.
            if (out_accept) begin
               if (tx_tlast_reg) begin
                  tx_tvalid_next = 1'b0;
                  state_next     = ST_DONE;
               end else begin
                  tx_tdata_next = ~crc_reg[15:8];
                  tx_tlast_next = 1'b1;
               end
            end
         end
         ST_DONE: begin
            tx_tvalid_next = 1'b0;
            state_next     = ST_IDLE;
         end
         default: begin
            tx_tvalid_next = 1'b0;
            state_next     = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_reg     <= ST_IDLE;
         kind_reg      <= KIND_HSK;
         tok_reg       <= 16'h0000;
         crc_reg       <= CRC16_INIT;
         trn_pend_reg  <= 1'b0;
         zlp_reg       <= 1'b0;
         trn_type_reg  <= 2'b00;
         tx_tvalid_reg <= 1'b0;
         tx_tlast_reg  <= 1'b0;
         tx_tdata_reg  <= 8'h00;
      end else begin
         state_reg     <= state_next;
         kind_reg      <= kind_next;
         tok_reg       <= tok_next;
         crc_reg       <= crc_next;
         trn_pend_reg  <= trn_pend_next;
         zlp_reg       <= zlp_next;
         trn_type_reg  <= trn_type_next;
         tx_tvalid_reg <= tx_tvalid_next;
         tx_tlast_reg  <= tx_tlast_next;
         tx_tdata_reg  <= tx_tdata_next;
      end
   end

   assign tx_tvalid_o  = tx_tvalid_reg;
   assign tx_tlast_o   = tx_tlast_reg;
   assign tx_tdata_o   = tx_tdata_reg;
   assign trn_tready_o = pay_ready;
   assign hsk_done_o   = (state_reg == ST_DONE) && (kind_reg == KIND_HSK);
   assign tok_done_o   = (state_reg == ST_DONE) && (kind_reg == KIND_TOK);

endmodule

// File: tb/tb_usb_packet_encoder.sv
// Directed bench for usb_packet_encoder: vector table of packets plus
// hand sequences for latency, priority, backpressure and mid-packet reset.
module tb_usb_packet_encoder;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        tx_tvalid;
   logic        tx_tready = 1'b1;
   logic        tx_tlast;
   logic [7:0]  tx_tdata;
   logic        hsk_send = 1'b0;
   logic        hsk_done;
   logic [1:0]  hsk_type = 2'b00;
   logic        tok_send = 1'b0;
   logic        tok_done;
   logic [1:0]  tok_type = 2'b00;
   logic [15:0] tok_data = 16'h0000;
   logic        trn_start = 1'b0;
   logic [1:0]  trn_type = 2'b00;
   logic        trn_tvalid = 1'b0;
   logic        trn_tready;
   logic        trn_tlast = 1'b0;
   logic [7:0]  trn_tdata = 8'h00;

   always #5 clock = ~clock;

   usb_packet_encoder dut (
      .clock        (clock),
      .reset        (reset),
      .tx_tvalid_o  (tx_tvalid),
      .tx_tready_i  (tx_tready),
      .tx_tlast_o   (tx_tlast),
      .tx_tdata_o   (tx_tdata),
      .hsk_send_i   (hsk_send),
      .hsk_done_o   (hsk_done),
      .hsk_type_i   (hsk_type),
      .tok_send_i   (tok_send),
      .tok_done_o   (tok_done),
      .tok_type_i   (tok_type),
      .tok_data_i   (tok_data),
      .trn_start_i  (trn_start),
      .trn_type_i   (trn_type),
      .trn_tvalid_i (trn_tvalid),
      .trn_tready_o (trn_tready),
      .trn_tlast_i  (trn_tlast),
      .trn_tdata_i  (trn_tdata)
   );

   int         checks = 0;
   int         errors = 0;
   logic [7:0] cap_d[$];
   logic       cap_l[$];
   int         pkt_cnt = 0;
   bit         bp_en = 1'b0;

   typedef struct {
      int         kind;   // 0 handshake, 1 token, 2 data
      logic [1:0] typ;
      logic [15:0] tokd;
      int         len;
      logic [7:0] pid;
   } vec_t;
   vec_t vecs[12];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %0h required %0h", name, act, req);
      end
   endtask

   function automatic logic [15:0] crc16_model(input logic [15:0] c, input logic [7:0] d);
      logic [15:0] r;
      r = c;
      for (int b = 0; b < 8; b++) begin
         r = (r[0] ^ d[b]) ? ((r >> 1) ^ 16'hA001) : (r >> 1);
      end
      return r;
   endfunction

   function automatic logic [7:0] pay_byte(input int seed, input int i);
      return 8'(seed * 29 + i * 73 + 17);
   endfunction

   // Monitor: a byte transfers at the next rising edge when valid&&ready here.
   logic       prev_v = 1'b0;
   logic       prev_r = 1'b0;
   logic       prev_l = 1'b0;
   logic [7:0] prev_d = 8'h00;
   initial begin
      forever begin
         @(negedge clock);
         if (!reset && prev_v && !prev_r) begin
            checks++;
            if (!(tx_tvalid && tx_tdata == prev_d && tx_tlast == prev_l)) begin
               errors++;
               $display("FAIL hold_stable: valid=%0b data=%02h last=%0b required valid=1 data=%02h last=%0b",
                        tx_tvalid, tx_tdata, tx_tlast, prev_d, prev_l);
            end
         end
         prev_v = tx_tvalid && !reset;
         prev_r = tx_tready;
         prev_d = tx_tdata;
         prev_l = tx_tlast;
         if (!reset && tx_tvalid && tx_tready) begin
            cap_d.push_back(tx_tdata);
            cap_l.push_back(tx_tlast);
            if (tx_tlast) pkt_cnt++;
         end
      end
   end

   initial begin
      forever begin
         @(posedge clock);
         #1;
         tx_tready = bp_en ? ($urandom_range(0, 2) != 0) : 1'b1;
      end
   end

   task automatic compare_bytes(input string name, input logic [7:0] exp_d[$]);
      chk({name, "_len"}, cap_d.size(), exp_d.size());
      for (int i = 0; i < exp_d.size(); i++) begin
         if (i < cap_d.size()) begin
            chk($sformatf("%s_b%0d", name, i), cap_d[i], exp_d[i]);
            chk($sformatf("%s_last%0d", name, i), cap_l[i], (i == exp_d.size() - 1) ? 1 : 0);
         end
      end
      $display("txn %s: %0d bytes captured", name, cap_d.size());
   endtask

   task automatic run_packet(input string name, input int kind, input logic [1:0] typ,
                             input logic [15:0] tokd, input logic [7:0] pay[$],
                             input logic [7:0] pid_exp, input bit gaps);
      logic [7:0]  exp_d[$];
      logic [15:0] crc;
      int          idx, cyc, start_pkts, nh, nt, len;
      bit          use_gaps;
      len = pay.size();
      use_gaps = gaps;
`ifdef USB_ENC_TVALID_END_EN
      use_gaps = 1'b0;
`endif
      exp_d.push_back(pid_exp);
      if (kind == 1) begin
         exp_d.push_back(tokd[7:0]);
         exp_d.push_back(tokd[15:8]);
      end
      if (kind == 2) begin
         crc = 16'hFFFF;
         for (int i = 0; i < len; i++) begin
            exp_d.push_back(pay[i]);
            crc = crc16_model(crc, pay[i]);
         end
         exp_d.push_back(~crc[7:0]);
         exp_d.push_back(~crc[15:8]);
      end
      cap_d.delete();
      cap_l.delete();
      start_pkts = pkt_cnt;
      @(posedge clock);
      #1;
      case (kind)
         0: begin hsk_send = 1'b1; hsk_type = typ; end
         1: begin tok_send = 1'b1; tok_type = typ; tok_data = tokd; end
         default: begin
            trn_start  = 1'b1;
            trn_type   = typ;
            trn_tvalid = (len > 0);
            trn_tdata  = (len > 0) ? pay[0] : 8'h00;
            trn_tlast  = (len == 1);
         end
      endcase
      idx = 0;
      cyc = 0;
      while (pkt_cnt == start_pkts && cyc < 3000) begin
         @(negedge clock);
         cyc++;
         if (trn_tvalid && trn_tready) idx++;
         @(posedge clock);
         #1;
         trn_start = 1'b0;
         if (kind == 2) begin
            trn_tvalid = (idx < len) && !(use_gaps && $urandom_range(0, 3) == 0);
            trn_tdata  = (idx < len) ? pay[idx] : 8'h00;
            trn_tlast  = (idx == len - 1);
         end
      end
      chk({name, "_timeout"}, (cyc >= 3000) ? 1 : 0, 0);
      nh = 0;
      nt = 0;
      for (int k = 0; k < 8; k++) begin
         @(negedge clock);
         if (hsk_done) nh++;
         if (tok_done) nt++;
         if (hsk_done || tok_done) begin
            @(posedge clock);
            #1;
            hsk_send = 1'b0;
            tok_send = 1'b0;
         end
      end
      hsk_send = 1'b0;
      tok_send = 1'b0;
      repeat (4) @(negedge clock);
      chk({name, "_hsk_done"}, nh, (kind == 0) ? 1 : 0);
      chk({name, "_tok_done"}, nt, (kind == 1) ? 1 : 0);
      compare_bytes(name, exp_d);
   endtask

   initial begin
      logic [7:0] pay[$];
      logic [7:0] exp_d[$];
      int         hd, td, cyc, start_pkts;

      vecs[0]  = '{0, 2'b00, 16'h0000, 0, 8'hD2};   // ACK
      vecs[1]  = '{0, 2'b10, 16'h0000, 0, 8'h5A};   // NAK
      vecs[2]  = '{0, 2'b11, 16'h0000, 0, 8'h1E};   // STALL
      vecs[3]  = '{0, 2'b01, 16'h0000, 0, 8'h96};   // NYET
      vecs[4]  = '{1, 2'b00, 16'h7080, 0, 8'hE1};   // OUT addr 0 ep 1
      vecs[5]  = '{1, 2'b10, 16'h7080, 0, 8'h69};   // IN addr 0 ep 1
      vecs[6]  = '{1, 2'b01, 16'hA5C3, 0, 8'hA5};   // SOF
      vecs[7]  = '{1, 2'b11, 16'h1234, 0, 8'h2D};   // SETUP
      vecs[8]  = '{2, 2'b00, 16'h0000, 10, 8'hC3};  // DATA0, 10 bytes
      vecs[9]  = '{2, 2'b10, 16'h0000, 0, 8'h4B};   // DATA1 ZLP
      vecs[10] = '{2, 2'b01, 16'h0000, 1, 8'h87};   // DATA2, 1 byte
      vecs[11] = '{2, 2'b11, 16'h0000, 3, 8'h0F};   // MDATA, 3 bytes

      repeat (3) @(negedge clock);
      chk("rst_tvalid", tx_tvalid, 0);
      chk("rst_tlast", tx_tlast, 0);
      chk("rst_tdata", tx_tdata, 0);
      chk("rst_hsk_done", hsk_done, 0);
      chk("rst_tok_done", tok_done, 0);
      chk("rst_trn_tready", trn_tready, 0);
      @(posedge clock);
      #1;
      reset = 1'b0;
      repeat (2) @(negedge clock);

      for (int r = 0; r < 12; r++) begin
         pay.delete();
         for (int i = 0; i < vecs[r].len; i++) pay.push_back(pay_byte(r, i));
         run_packet($sformatf("row%0d", r), vecs[r].kind, vecs[r].typ, vecs[r].tokd,
                    pay, vecs[r].pid, 1'b0);
      end

      // Known CRC-16/USB check value for "123456789" is 0xB4C8.
      pay.delete();
      for (int i = 0; i < 9; i++) pay.push_back(8'h31 + 8'(i));
      run_packet("ascii9", 2, 2'b00, 16'h0000, pay, 8'hC3, 1'b0);
      if (cap_d.size() == 12) begin
         chk("ascii9_crc_lo", cap_d[10], 8'hC8);
         chk("ascii9_crc_hi", cap_d[11], 8'hB4);
      end

      // PID byte appears the cycle after the request is sampled.
      cap_d.delete();
      cap_l.delete();
      @(posedge clock);
      #1;
      hsk_send = 1'b1;
      hsk_type = 2'b00;
      @(negedge clock);
      chk("lat_before", tx_tvalid, 0);
      @(negedge clock);
      chk("lat_valid", tx_tvalid, 1);
      chk("lat_data", tx_tdata, 8'hD2);
      chk("lat_last", tx_tlast, 1);
      @(negedge clock);
      chk("lat_done", hsk_done, 1);
      @(posedge clock);
      #1;
      hsk_send = 1'b0;
      @(negedge clock);
      chk("lat_done_pulse", hsk_done, 0);
      repeat (4) @(negedge clock);
      chk("lat_no_resend", cap_d.size(), 1);

      // Backpressure and payload gaps must not change the byte sequence.
      bp_en = 1'b1;
      pay.delete();
      for (int i = 0; i < 10; i++) pay.push_back(pay_byte(8, i));
      run_packet("bp_data0", 2, 2'b00, 16'h0000, pay, 8'hC3, 1'b1);
      pay.delete();
      run_packet("bp_tok", 1, 2'b10, 16'h7080, pay, 8'h69, 1'b0);
      bp_en = 1'b0;

      // Simultaneous requests: handshake, then token, then pending ZLP.
      cap_d.delete();
      cap_l.delete();
      start_pkts = pkt_cnt;
      @(posedge clock);
      #1;
      hsk_send   = 1'b1;
      hsk_type   = 2'b10;
      tok_send   = 1'b1;
      tok_type   = 2'b00;
      tok_data   = 16'h7080;
      trn_start  = 1'b1;
      trn_type   = 2'b00;
      trn_tvalid = 1'b0;
      @(posedge clock);
      #1;
      trn_start = 1'b0;
      hd = 0;
      td = 0;
      cyc = 0;
      while ((pkt_cnt - start_pkts < 3) && cyc < 300) begin
         @(negedge clock);
         cyc++;
         if (hsk_done) hd++;
         if (tok_done) td++;
         @(posedge clock);
         #1;
         if (hd > 0) hsk_send = 1'b0;
         if (td > 0) tok_send = 1'b0;
      end
      hsk_send = 1'b0;
      tok_send = 1'b0;
      repeat (6) @(negedge clock);
      chk("prio_timeout", (cyc >= 300) ? 1 : 0, 0);
      chk("prio_hsk_done", hd, 1);
      chk("prio_tok_done", td, 1);
      exp_d = '{8'h5A, 8'hE1, 8'h80, 8'h70, 8'hC3, 8'h00, 8'h00};
      chk("prio_len", cap_d.size(), exp_d.size());
      for (int i = 0; i < exp_d.size(); i++) begin
         if (i < cap_d.size()) begin
            chk($sformatf("prio_b%0d", i), cap_d[i], exp_d[i]);
            chk($sformatf("prio_last%0d", i), cap_l[i], (i == 0 || i == 3 || i == 6) ? 1 : 0);
         end
      end
      $display("txn prio: %0d bytes captured", cap_d.size());

      // Reset in the middle of a payload aborts with no done pulse.
      @(posedge clock);
      #1;
      trn_start  = 1'b1;
      trn_type   = 2'b00;
      trn_tvalid = 1'b1;
      trn_tdata  = 8'hAA;
      trn_tlast  = 1'b0;
      @(posedge clock);
      #1;
      trn_start = 1'b0;
      repeat (5) @(posedge clock);
      #1;
      chk("rstmid_in_payload", trn_tready, 1);
      reset = 1'b1;
      @(posedge clock);
      @(negedge clock);
      chk("rstmid_tvalid", tx_tvalid, 0);
      chk("rstmid_trn_tready", trn_tready, 0);
      @(posedge clock);
      #1;
      reset      = 1'b0;
      trn_tvalid = 1'b0;
      hd = 0;
      for (int k = 0; k < 4; k++) begin
         @(negedge clock);
         if (tx_tvalid || hsk_done || tok_done || trn_tready) hd++;
      end
      chk("rstmid_idle_after", hd, 0);
      $display("txn rstmid: reset during payload");
      cap_d.delete();
      cap_l.delete();
      pay.delete();
      run_packet("after_rst_ack", 0, 2'b00, 16'h0000, pay, 8'hD2, 1'b0);
      pay.delete();
      for (int i = 0; i < 4; i++) pay.push_back(pay_byte(3, i));
      run_packet("after_rst_data1", 2, 2'b10, 16'h0000, pay, 8'h4B, 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
